// File: rtl/stove_button_conditioner.sv
// Pushbutton conditioner for the stove controller: per channel a two-flop
// synchronizer, debounce filter, press-edge strobe and optional auto-repeat.
module stove_button_conditioner #(
  parameter int                    CHANNELS        = 5,
  parameter int                    DEBOUNCE_CYCLES = 500000,
  parameter logic [CHANNELS-1:0]   REPEAT_MASK     = 5'b11000,
  parameter int                    REPEAT_DELAY    = 25000000,
  parameter int                    REPEAT_PERIOD   = 10000000,
  parameter int                    ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                async_reset,
  input  logic [CHANNELS-1:0] buttons_raw,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] pulse
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);
  localparam logic            RAW_IDLE    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HELD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic            sync1, sync2;
    logic            level;          // registered, polarity-normalized input
    logic            pressed_q, pulse_q;
    logic [DB_W-1:0] db_cnt;
    logic [RP_W-1:0] rep_cnt;
    logic [1:0]      state;
    logic            rise, fall, rep_fire;

    always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      rise     = 1'b0;
      fall     = 1'b0;
      rep_fire = 1'b0;
      if (level != pressed_q && db_cnt == DB_LAST) begin
        rise = level;
        fall = ~level;
      end
      // A release on this edge cancels any repeat that would have fired.
      if (REPEAT_MASK[i] && !fall) begin
        if (state == ST_HELD && rep_cnt == DELAY_LAST)
          rep_fire = 1'b1;
        if (state == ST_REPEAT && rep_cnt == PERIOD_LAST)
          rep_fire = 1'b1;
      end
    end

    // NOTE: all state updates are non-blocking so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
        sync1     <= RAW_IDLE;
        sync2     <= RAW_IDLE;
        level     <= 1'b0;
        pressed_q <= 1'b0;
        pulse_q   <= 1'b0;
        db_cnt    <= '0;
        rep_cnt   <= '0;
        state     <= ST_IDLE;
      end else begin
        sync1 <= buttons_raw[i];
        sync2 <= sync1;
        level <= (ACTIVE_LOW != 0) ? ~sync2 : sync2;

        if (level == pressed_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          pressed_q <= level;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end

        // Masking with the current strobe keeps a period-1 repeat toggling.
        pulse_q <= (rise | rep_fire) & ~pulse_q;

        case (state)
          ST_IDLE: begin
            if (rise) begin
              state   <= ST_HELD;
              rep_cnt <= '0;
            end
          end
          ST_HELD: begin
            if (fall) begin
              state <= ST_IDLE;
            end else if (REPEAT_MASK[i]) begin
              if (rep_fire) begin
                state   <= ST_REPEAT;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
          end
          ST_REPEAT: begin
            if (fall)
              state <= ST_IDLE;
            else if (rep_fire)
              rep_cnt <= '0;
            else
              rep_cnt <= rep_cnt + 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign pressed[i] = pressed_q;
    assign pulse[i]   = pulse_q;
  end

endmodule
